// File: rtl/coprocessor_pkg.sv
// coprocessor_pkg: shared state encoding, default widths and the block-address helper
//   used by pe_task_controller and pe_mac_unit.
package coprocessor_pkg;
  localparam int BLOCK_WORDS_DEF = 4;
  localparam int INDEX_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    s_Idle   = 3'd0,
    s_Ack    = 3'd1,
    s_Read   = 3'd2,
    s_Drain  = 3'd3,
    s_Write  = 3'd4,
    s_Report = 3'd5
  } state_t;
  // base + index*scale + offset; callers truncate to their address width so the sum wraps
  function automatic logic [31:0] block_addr(input logic [31:0] base, input logic [31:0] index,
                                             input logic [31:0] scale, input logic [31:0] offset);
    return base + index * scale + offset;
  endfunction
endpackage

// File: rtl/pe_mac_unit.sv
// pe_mac_unit: unsigned multiply-accumulate for one dot product.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the accumulator (and overflow flag) for a new task
//   en         : accumulate a*b this cycle
//   a, b       : operands
//   result     : current dot-product value
// Macro PE_TASK_SATURATE_EN: sticky overflow forces result to all ones.
module pe_mac_unit
  import coprocessor_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);
  logic [DATA_WIDTH-1:0] acc;
`ifdef PE_TASK_SATURATE_EN
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH:0] sum;
  logic ovf;
  assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
  assign sum = {{(DATA_WIDTH+1){1'b0}}, acc} + {1'b0, prod};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum[DATA_WIDTH-1:0];
      ovf <= ovf | (|sum[2*DATA_WIDTH:DATA_WIDTH]);
    end
  assign result = ovf ? '1 : acc;
`else
  // only the low word of each product can reach a modulo-2^DATA_WIDTH sum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clear) acc <= '0;
    else if (en) acc <= acc + DATA_WIDTH'(a * b);
  assign result = acc;
`endif
endmodule

// File: rtl/pe_task_controller.sv
// pe_task_controller: per-slot task engine; accepts a block index pair, reads an A row-block
//   and B column-block under grant, accumulates their dot product and writes it back.
//   i_Clock, i_Reset_n            : clock, asynchronous active-low reset
//   i_Indexes_Ready / o_Indexes_Received, i_Row_Index, i_Column_Index : index handshake
//   i_Base_A/B/C, i_Result_Stride : configuration, sampled at acceptance
//   o_Grant_Request, i_Grant      : shared memory arbitration
//   o_Memory_Address/Read/Write/Write_Data, i_Memory_Read_Data : memory port
//   o_Result_Ready, i_Result_Ack  : completion handshake
// Macro PE_TASK_SATURATE_EN: saturate the written result on overflow (in pe_mac_unit).
module pe_task_controller
  import coprocessor_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Indexes_Ready,
  input  logic [INDEX_WIDTH-1:0] i_Row_Index,
  input  logic [INDEX_WIDTH-1:0] i_Column_Index,
  output logic                   o_Indexes_Received,
  input  logic [ADDR_WIDTH-1:0]  i_Base_A,
  input  logic [ADDR_WIDTH-1:0]  i_Base_B,
  input  logic [ADDR_WIDTH-1:0]  i_Base_C,
  input  logic [ADDR_WIDTH-1:0]  i_Result_Stride,
  output logic                   o_Grant_Request,
  input  logic                   i_Grant,
  output logic [ADDR_WIDTH-1:0]  o_Memory_Address,
  output logic                   o_Memory_Read,
  output logic                   o_Memory_Write,
  output logic [DATA_WIDTH-1:0]  o_Memory_Write_Data,
  input  logic [DATA_WIDTH-1:0]  i_Memory_Read_Data,
  output logic                   o_Result_Ready,
  input  logic                   i_Result_Ack
);
  localparam int K_W = $clog2(2 * BLOCK_WORDS);
  localparam int A_W = $clog2(BLOCK_WORDS);
  state_t state, state_next;
  logic [K_W-1:0] k, rd_k;
  logic rd_valid;
  logic [INDEX_WIDTH-1:0] row, col;
  logic [ADDR_WIDTH-1:0] base_a, base_b, base_c, stride;
  logic [DATA_WIDTH-1:0] a_buf [BLOCK_WORDS];
  logic [DATA_WIDTH-1:0] result;
  logic accept, issue, last_issue, b_return;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  assign accept = state == s_Idle && i_Indexes_Ready;
  assign issue = state == s_Read && i_Grant;
  assign last_issue = issue && k == K_W'(2 * BLOCK_WORDS - 1);
  // rd_k tags the word returning this cycle; data lags its strobe by one cycle
  assign b_return = rd_valid && rd_k >= K_W'(BLOCK_WORDS);
  assign rd_addr = k < K_W'(BLOCK_WORDS)
    ? ADDR_WIDTH'(block_addr(32'(base_a), 32'(row), 32'(BLOCK_WORDS), 32'(k)))
    : ADDR_WIDTH'(block_addr(32'(base_b), 32'(col), 32'(BLOCK_WORDS), 32'(k - K_W'(BLOCK_WORDS))));
  assign wr_addr = ADDR_WIDTH'(block_addr(32'(base_c), 32'(row), 32'(stride), 32'(col)));
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) state <= s_Idle;
    else state <= state_next;
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      k <= '0;
      rd_k <= '0;
      rd_valid <= 1'b0;
      row <= '0;
      col <= '0;
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
      stride <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) a_buf[i] <= '0;
    end else begin
      rd_valid <= issue;
      rd_k <= k;
      if (accept) begin
        row <= i_Row_Index;
        col <= i_Column_Index;
        base_a <= i_Base_A;
        base_b <= i_Base_B;
        base_c <= i_Base_C;
        stride <= i_Result_Stride;
        k <= '0;
      end else if (issue) k <= k + K_W'(1);
      if (rd_valid && !b_return) a_buf[A_W'(rd_k)] <= i_Memory_Read_Data;
    end
  pe_mac_unit #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .clk    (i_Clock),
    .rst_n  (i_Reset_n),
    .clear  (accept),
    .en     (b_return),
    .a      (a_buf[A_W'(rd_k - K_W'(BLOCK_WORDS))]),
    .b      (i_Memory_Read_Data),
    .result (result)
  );
  always_comb begin
    state_next = state;
    o_Indexes_Received = 1'b0;
    o_Grant_Request = 1'b0;
    o_Memory_Read = 1'b0;
    o_Memory_Write = 1'b0;
    o_Memory_Address = '0;
    o_Memory_Write_Data = '0;
    o_Result_Ready = 1'b0;
    case (state)
      s_Idle: state_next = i_Indexes_Ready ? s_Ack : s_Idle;
      s_Ack: begin
        o_Indexes_Received = 1'b1;
        state_next = s_Read;
      end
      s_Read: begin
        o_Grant_Request = 1'b1;
        o_Memory_Read = i_Grant;
        o_Memory_Address = i_Grant ? rd_addr : '0;
        state_next = last_issue ? s_Drain : s_Read;
      end
      s_Drain: state_next = s_Write;
      s_Write: begin
        o_Grant_Request = 1'b1;
        o_Memory_Write = i_Grant;
        o_Memory_Address = i_Grant ? wr_addr : '0;
        o_Memory_Write_Data = i_Grant ? result : '0;
        state_next = i_Grant ? s_Report : s_Write;
      end
      s_Report: begin
        o_Result_Ready = 1'b1;
        state_next = i_Result_Ack ? s_Idle : s_Report;
      end
      default: state_next = s_Idle;
    endcase
  end
endmodule

// File: tb/tb_pe_task_controller.sv
// tb_pe_task_controller: scoreboard bench; tasks queue expected bus accesses, a monitor checks them.
module tb_pe_task_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_Indexes_Ready = 1'b0;
  logic [7:0] i_Row_Index = '0, i_Column_Index = '0;
  logic o_Indexes_Received;
  logic [15:0] i_Base_A = '0, i_Base_B = '0, i_Base_C = '0, i_Result_Stride = '0;
  logic o_Grant_Request;
  logic i_Grant = 1'b1;
  logic [15:0] o_Memory_Address;
  logic o_Memory_Read, o_Memory_Write;
  logic [31:0] o_Memory_Write_Data;
  logic [31:0] i_Memory_Read_Data = '0;
  logic o_Result_Ready;
  logic i_Result_Ack = 1'b0;

  always #5 clk = ~clk;

  pe_task_controller dut (
    .i_Clock             (clk),
    .i_Reset_n           (rst_n),
    .i_Indexes_Ready     (i_Indexes_Ready),
    .i_Row_Index         (i_Row_Index),
    .i_Column_Index      (i_Column_Index),
    .o_Indexes_Received  (o_Indexes_Received),
    .i_Base_A            (i_Base_A),
    .i_Base_B            (i_Base_B),
    .i_Base_C            (i_Base_C),
    .i_Result_Stride     (i_Result_Stride),
    .o_Grant_Request     (o_Grant_Request),
    .i_Grant             (i_Grant),
    .o_Memory_Address    (o_Memory_Address),
    .o_Memory_Read       (o_Memory_Read),
    .o_Memory_Write      (o_Memory_Write),
    .o_Memory_Write_Data (o_Memory_Write_Data),
    .i_Memory_Read_Data  (i_Memory_Read_Data),
    .o_Result_Ready      (o_Result_Ready),
    .i_Result_Ack        (i_Result_Ack)
  );

  logic [31:0] mem [logic [15:0]];
  logic [15:0] exp_rd [$];
  logic [47:0] exp_wr [$];
  int n_cmp = 0, n_bad = 0, n_rcv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: data for a read strobed in cycle t is presented throughout cycle t+1
  initial begin
    logic r;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      r = o_Memory_Read;
      a = o_Memory_Address;
      @(posedge clk);
      #1;
      i_Memory_Read_Data = r ? mem[a] : 32'hDEAD_BEEF;
    end
  end

  // monitor: pops the scoreboard whenever the DUT drives a strobe
  initial forever begin
    @(negedge clk);
    if (o_Indexes_Received) n_rcv++;
    if (o_Memory_Read || o_Memory_Write) chk("strobe_has_grant", {63'd0, i_Grant}, 64'd1);
    if (o_Memory_Read) begin
      if (exp_rd.size() == 0) chk("read_unexpected", {48'd0, o_Memory_Address}, 64'hFFFF_FFFF);
      else chk("read_addr", {48'd0, o_Memory_Address}, {48'd0, exp_rd.pop_front()});
    end else if (o_Memory_Write) begin
      if (exp_wr.size() == 0) chk("write_unexpected", {16'd0, o_Memory_Address, o_Memory_Write_Data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("write_addr_data", {16'd0, o_Memory_Address, o_Memory_Write_Data}, {16'd0, exp_wr.pop_front()});
    end else chk("idle_bus_zero", {16'd0, o_Memory_Address, o_Memory_Write_Data}, 64'd0);
  end

  function automatic logic [63:0] outs();
    return {11'd0, o_Indexes_Received, o_Grant_Request, o_Memory_Read, o_Memory_Write,
            o_Result_Ready, o_Memory_Address, o_Memory_Write_Data};
  endfunction

  task automatic start(input logic [15:0] ba, bb, bc, st, input logic [7:0] row, col,
                       input logic [15:0] a_at, b_at, input logic [3:0][31:0] av, bv, input int n_rd);
    for (int i = 0; i < 4; i++) begin
      mem[16'(a_at + 16'(i))] = av[i];
      mem[16'(b_at + 16'(i))] = bv[i];
    end
    for (int i = 0; i < n_rd; i++) exp_rd.push_back(i < 4 ? 16'(a_at + 16'(i)) : 16'(b_at + 16'(i - 4)));
    @(posedge clk);
    #1;
    i_Base_A = ba;
    i_Base_B = bb;
    i_Base_C = bc;
    i_Result_Stride = st;
    i_Row_Index = row;
    i_Column_Index = col;
    i_Indexes_Ready = 1'b1;
    i_Grant = 1'b1;
  endtask

  task automatic run_task(input string tag, input logic [15:0] ba, bb, bc, st, input logic [7:0] row, col,
                          input logic [15:0] a_at, b_at, input logic [3:0][31:0] av, bv,
                          input logic [15:0] wr_addr, input logic [31:0] res,
                          input bit toggle, input int hold, input int exp_cyc);
    int n, rcv0;
    rcv0 = n_rcv;
    exp_wr.push_back({wr_addr, res});
    start(ba, bb, bc, st, row, col, a_at, b_at, av, bv, 8);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      i_Grant = toggle ? (n % 2 == 0) : 1'b1;
      if (n >= hold) i_Indexes_Ready = 1'b0;
    end while (!o_Result_Ready && n < 200);
    chk({tag, "_ready_cycle"}, 64'(n), 64'(exp_cyc));
    i_Grant = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk({tag, "_ready_held"}, {63'd0, o_Result_Ready}, 64'd1);
    end
    i_Result_Ack = 1'b1;
    @(posedge clk);
    #1;
    i_Result_Ack = 1'b0;
    chk({tag, "_ready_dropped"}, {63'd0, o_Result_Ready}, 64'd0);
    @(negedge clk);
    chk({tag, "_received_once"}, 64'(n_rcv - rcv0), 64'd1);
    chk({tag, "_scoreboard_empty"}, 64'(exp_rd.size() + exp_wr.size()), 64'd0);
  endtask

  localparam logic [3:0][31:0] A_V = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [3:0][31:0] B_V = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [3:0][31:0] ONES = {4{32'hFFFF_FFFF}};
`ifdef PE_TASK_SATURATE_EN
  localparam logic [31:0] OVF_RES = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF_RES = 32'h0000_0004;
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    run_task("func", 16'h0100, 16'h0200, 16'h0300, 16'd8, 8'd2, 8'd3, 16'h0108, 16'h020C,
             A_V, B_V, 16'h0313, 32'd70, 1'b0, 1, 12);
    run_task("toggle", 16'h0100, 16'h0200, 16'h0300, 16'd8, 8'd2, 8'd3, 16'h0108, 16'h020C,
             A_V, B_V, 16'h0313, 32'd70, 1'b1, 1, 19);
    run_task("hold", 16'h0100, 16'h0200, 16'h0300, 16'd8, 8'd2, 8'd3, 16'h0108, 16'h020C,
             A_V, B_V, 16'h0313, 32'd70, 1'b0, 3, 12);
    run_task("ovf", 16'h0100, 16'h0200, 16'h0300, 16'd8, 8'd2, 8'd3, 16'h0108, 16'h020C,
             ONES, ONES, 16'h0313, OVF_RES, 1'b0, 1, 12);
    // abort: reads at cycles 2 and 3 complete, reset lands inside the cycle-4 read
    start(16'h0100, 16'h0200, 16'h0300, 16'd8, 8'd2, 8'd3, 16'h0108, 16'h020C, ONES, ONES, 2);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      i_Indexes_Ready = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midtask_reset_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midtask_reset_scoreboard", 64'(exp_rd.size()), 64'd0);
    run_task("after_reset", 16'h0100, 16'h0200, 16'h0300, 16'd8, 8'd2, 8'd3, 16'h0108, 16'h020C,
             A_V, B_V, 16'h0313, 32'd70, 1'b0, 1, 12);
    run_task("wrap", 16'h0100, 16'hFFFE, 16'h0300, 16'd8, 8'd0, 8'd0, 16'h0100, 16'hFFFE,
             {32'd1, 32'd1, 32'd1, 32'd1}, {32'd5, 32'd4, 32'd3, 32'd2}, 16'h0300, 32'd14, 1'b0, 1, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
